// File: rtl/lfo_ctrl.sv
// ============================================================================
//  Module   : lfo_ctrl
//  Purpose  : Sample-rate scheduler, switch debouncer and depth ramp for the
//             LFO generator.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module lfo_ctrl #(
   parameter int CLK_DIV        = 544,
   parameter int DEBOUNCE_TICKS = 441,
   parameter int RAMP_TICKS     = 64
) (
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic [3:0] freqSw_i,
   input  logic [3:0] depthSw_i,
   input  logic       fifoFull_i,
   output logic [3:0] freqSetting_o,
   output logic [3:0] scaleFactor_o,
   output logic       lfoUpdate_o,
   output logic       ramping_o,
   output logic       overrun_o
);

   localparam int c_DIV_W  = $clog2(CLK_DIV);
   localparam int c_DB_W   = $clog2(DEBOUNCE_TICKS + 1);
   localparam int c_RAMP_W = $clog2(RAMP_TICKS + 1);

   localparam logic [c_DIV_W-1:0]  c_DIV_LAST  = c_DIV_W'(CLK_DIV - 1);
   localparam logic [c_DB_W-1:0]   c_DB_FULL   = c_DB_W'(DEBOUNCE_TICKS);
   localparam logic [c_RAMP_W-1:0] c_RAMP_FULL = c_RAMP_W'(RAMP_TICKS);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RAMP = 1'b1
   } state_t;

   // ---------------------------------------------------------------- divider
   logic [c_DIV_W-1:0] r_div_cnt;
   logic               w_tick;

   assign w_tick = (r_div_cnt == c_DIV_LAST);

   always_ff @(posedge clk_i) begin
      if (reset_i)      r_div_cnt <= '0;
      else if (w_tick)  r_div_cnt <= '0;
      else              r_div_cnt <= r_div_cnt + c_DIV_W'(1);
   end

   // ------------------------------------------------------ update scheduling
   logic r_pending;
   logic r_update;
   logic r_overrun;
   logic w_req;

   assign w_req = w_tick | r_pending;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_pending <= 1'b0;
         r_update  <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         r_update  <= w_req & ~fifoFull_i;
         r_pending <= w_req & fifoFull_i;
         // Only one update can be held; a second tick while held is lost.
         if (w_tick & r_pending & fifoFull_i)
            r_overrun <= 1'b1;
      end
   end

   // ------------------------------------------- synchronize + debounce (x2)
   logic [1:0][3:0] w_sw_raw;
   logic [3:0]      w_cand [2];
   logic [1:0]      w_commit;

   assign w_sw_raw = {depthSw_i, freqSw_i};

   for (genvar b = 0; b < 2; b++) begin : g_bus
      logic [3:0]        r_meta;
      logic [3:0]        r_sync;
      logic [3:0]        r_cand;
      logic [c_DB_W-1:0] r_cnt;
      logic [c_DB_W-1:0] w_cnt_inc;

      assign w_cnt_inc   = r_cnt + c_DB_W'(1);
      assign w_cand[b]   = r_cand;
      assign w_commit[b] = w_tick && (r_sync == r_cand) &&
                           (r_cnt != c_DB_FULL) && (w_cnt_inc == c_DB_FULL);

      always_ff @(posedge clk_i) begin
         if (reset_i) begin
            r_meta <= '0;
            r_sync <= '0;
            r_cand <= '0;
            r_cnt  <= '0;
         end else begin
            r_meta <= w_sw_raw[b];
            r_sync <= r_meta;
            if (w_tick) begin
               if (r_sync != r_cand) begin
                  r_cand <= r_sync;
                  r_cnt  <= '0;
               end else if (r_cnt != c_DB_FULL) begin
                  r_cnt  <= w_cnt_inc;
               end
            end
         end
      end
   end

   // ------------------------------------------------------ committed values
   logic [3:0] r_freq;
   logic [3:0] r_target;
   logic [3:0] w_target_nxt;

   // The FSM looks at the incoming target so ramp entry lands in the tick cycle.
   assign w_target_nxt = w_commit[1] ? w_cand[1] : r_target;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_freq   <= '0;
         r_target <= '0;
      end else begin
         if (w_commit[0]) r_freq   <= w_cand[0];
         if (w_commit[1]) r_target <= w_cand[1];
      end
   end

   // --------------------------------------------------------------- depth FSM
   state_t              r_state, w_state_nxt;
   logic [3:0]          r_scale, w_scale_nxt;
   logic [c_RAMP_W-1:0] r_ramp_cnt, w_ramp_cnt_nxt;
   logic [c_RAMP_W-1:0] w_ramp_inc;

   assign w_ramp_inc = r_ramp_cnt + c_RAMP_W'(1);

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_state    <= ST_IDLE;
         r_scale    <= '0;
         r_ramp_cnt <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_scale    <= w_scale_nxt;
         r_ramp_cnt <= w_ramp_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_scale_nxt    = r_scale;
      w_ramp_cnt_nxt = r_ramp_cnt;
      case (r_state)
         ST_IDLE: begin
            if (w_target_nxt != r_scale) begin
               w_state_nxt    = ST_RAMP;
               w_ramp_cnt_nxt = '0;
            end
         end
         ST_RAMP: begin
            if (w_tick) begin
               if (w_ramp_inc == c_RAMP_FULL) begin
                  w_ramp_cnt_nxt = '0;
                  if (w_target_nxt > r_scale)      w_scale_nxt = r_scale + 4'd1;
                  else if (w_target_nxt < r_scale) w_scale_nxt = r_scale - 4'd1;
               end else begin
                  w_ramp_cnt_nxt = w_ramp_inc;
               end
            end
            if (w_scale_nxt == w_target_nxt)
               w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   assign freqSetting_o = r_freq;
   assign scaleFactor_o = r_scale;
   assign lfoUpdate_o   = r_update;
   assign ramping_o     = (r_state == ST_RAMP);
   assign overrun_o     = r_overrun;

endmodule

`default_nettype wire

// File: doc/lfo_ctrl.md
# lfo_ctrl

Control and scheduling block for the LFO generator.
- Divides the system clock down to the 44.1 kHz sample rate and issues the per-sample update strobe (`FIFOupdate_i` on the LFO generator).
- Honours output-FIFO backpressure.
- Debounces the frequency and depth DIP switches.
- Ramps the depth (scale factor) one LSB at a time so depth changes produce no audible steps.
- Sits between the board switches/FIFO and the LFO generator's `freqSetting_i`, `scaleFactor_i` and `FIFOupdate_i`.

## Interface
Parameters:
- CLK_DIV, 544 — system clocks per sample tick (24 MHz / 44.1 kHz); legal range ≥ 4.
- DEBOUNCE_TICKS, 441 — consecutive stable sample ticks required to commit a switch value (10 ms); legal range ≥ 1.
- RAMP_TICKS, 64 — sample ticks per one-LSB depth step; legal range ≥ 1.

Ports:
- clk_i  in  1  system clock.
- reset_i  in  1  synchronous, active-high reset.
- freqSw_i  in  4  raw frequency DIP switches (asynchronous).
- depthSw_i  in  4  raw depth DIP switches (asynchronous).
- fifoFull_i  in  1  downstream sample FIFO full; blocks updates.
- freqSetting_o  out  4  committed frequency code to the LFO generator.
- scaleFactor_o  out  4  ramped depth to the LFO generator.
- lfoUpdate_o  out  1  one-cycle update strobe to the LFO generator.
- ramping_o  out  1  high while scaleFactor_o ≠ depth target.
- overrun_o  out  1  sticky flag: a sample tick was lost to backpressure.

## Operation
- **Reset:** all outputs 0. Internal state cleared: divider, pending flag, synchronizers, candidates, debounce counters, committed values, depth target, ramp counter. FSM returns to IDLE. Reset takes priority over every other event, including mid-ramp and a pending update.
- **Divider:** `divCnt` counts 0..CLK_DIV-1 and wraps. `tick` is asserted combinationally while `divCnt == CLK_DIV-1`.
- **Update scheduling:**
  - `req = tick | pending`.
  - `lfoUpdate_o <= req & ~fifoFull_i`.
  - `pending <= req & fifoFull_i`.
  - At most one update is held pending. If `tick` arrives while `pending` is already set and `fifoFull_i` is high, `overrun_o` is set and stays set until reset.
- **Synchronizer:** each switch bus passes through a 2-flop synchronizer before any other logic.
- **Debounce:** independent per bus; evaluated only on `tick`.
  - If the synced value ≠ candidate: candidate <= synced, cnt <= 0.
  - Otherwise, if cnt < DEBOUNCE_TICKS: cnt <= cnt+1. When cnt+1 == DEBOUNCE_TICKS, the candidate is committed.
  - The counter saturates at DEBOUNCE_TICKS, so commit fires once per stable value.
  - Net effect: a new value seen on tick k commits on tick k+DEBOUNCE_TICKS. A bus that changes at least every DEBOUNCE_TICKS ticks never commits.
- **Frequency:** `freqSetting_o` takes the committed frequency in the commit cycle. There is no ramp.
- **Depth:** the committed depth becomes `target`.
- **Depth FSM:**
  - IDLE: `scaleFactor_o == target`. On the cycle `target ≠ scaleFactor_o` is first seen, go to RAMP with rampCnt <= 0.
  - RAMP: on each tick, rampCnt increments. When it reaches RAMP_TICKS, rampCnt <= 0 and `scaleFactor_o` moves one step toward `target` (+1 or −1, 4-bit unsigned, never wraps).
  - Direction is re-evaluated at every step, so a target change mid-ramp reverses or extends the ramp without resetting rampCnt.
  - RAMP → IDLE in the cycle the step makes `scaleFactor_o == target`.
  - `ramping_o` is high exactly when the state is RAMP.
- A frequency commit and a depth commit on the same tick are both applied in that cycle.

## Timing
- `tick` at cycle N gives `lfoUpdate_o` high at cycle N+1 (registered), provided `fifoFull_i` is low at N.
- A held update fires in the cycle after the first cycle in which `fifoFull_i` is low.
- After reset release, the first `tick` falls at cycle CLK_DIV-1; with CLK_DIV = 4, ticks fall at cycles 3, 7, 11, … and the first `lfoUpdate_o` is at cycle 4.
- Switch-to-commit latency: 2 clocks (sync) plus wait to the next tick, plus DEBOUNCE_TICKS ticks.
- Depth step i after a target change lands on tick i·RAMP_TICKS, counted from RAMP entry. A full 0→15 ramp takes 15·RAMP_TICKS ticks.
- `freqSetting_o`, `scaleFactor_o` and `ramping_o` change only in tick cycles. They are therefore stable at least CLK_DIV-1 cycles before the next `lfoUpdate_o`.

## Test plan
All scenarios use CLK_DIV=4, DEBOUNCE_TICKS=3, RAMP_TICKS=2.
- **Reset and divider:** hold reset 5 cycles, then release with `fifoFull_i`=0 → all outputs 0 during reset; `lfoUpdate_o` pulses at cycles 4, 8, 12, … each one cycle wide.
- **Backpressure and overrun:**
  - Raise `fifoFull_i` across one tick, drop it 2 cycles later → exactly one delayed pulse in the cycle after the drop; `overrun_o` stays 0.
  - Hold `fifoFull_i` across two ticks → `overrun_o`=1 and exactly one pulse after release.
- **Frequency debounce:**
  - `freqSw_i`=0101 held steady → `freqSetting_o`=0101 on the third tick after the candidate is captured.
  - Toggle 0101/1010 every tick → `freqSetting_o` never changes.
- **Depth ramp up:** `depthSw_i` 0000→1111 held → after commit, `scaleFactor_o` increments every 2 ticks, reaches 15 after 30 ticks; `ramping_o` falls in the same cycle.
- **Mid-ramp reversal:** at `scaleFactor_o`=6 during an up-ramp, commit `depthSw_i`=0010 → `scaleFactor_o` steps 5, 4, 3, 2 at 2-tick spacing; `ramping_o` low at 2.
- **Reset mid-ramp:** assert reset at `scaleFactor_o`=9 with a pending update → the next cycle shows all outputs 0, FSM in IDLE, no `lfoUpdate_o` pulse.
